decodificador_varredura: RTL and testbench
==========================================

DECODIFICADOR_VARREDURA -- requirements
Module: decodificador_varredura

Interface
REQ-001 Parameter N, default 3: address width; output width W = 2**N.
REQ-002 Parameter DWELL, default 4: clock cycles per scan step; legal range 1..65535.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 E  input  1  enable; when 0, outputs are blanked.
REQ-006 mode  input  1  0 = direct decode of A; 1 = auto-scan.
REQ-007 load  input  1  in scan mode, load A as the scan position.
REQ-008 A  input  N  address input.
REQ-009 S  output  W  registered one-hot output.
REQ-010 idx  output  N  registered current position.
REQ-011 wrap  output  1  one-cycle pulse when the scan position rolls from W-1 to 0.

Function
REQ-012 The block SHALL be a three-state machine: OFF (E=0), DIRECT (E=1, mode=0) and SCAN (E=1, mode=1); the state is re-evaluated every cycle from E and mode.
REQ-013 All outputs SHALL be registered; an input change SHALL appear on the outputs one cycle later.
REQ-014 In OFF, S SHALL be 0, idx and the dwell counter SHALL hold their values, and wrap SHALL be 0.
REQ-015 In DIRECT, on each edge: idx <= A, S <= one-hot(A) (bit A set), dwell counter <= 0, wrap <= 0.
REQ-016 In SCAN without load:
- Dwell counter increments each cycle.
- When the counter equals DWELL-1, it clears and idx advances by 1 modulo W.
- S <= one-hot of the new idx.
REQ-017 In SCAN, wrap SHALL be 1 for exactly the cycle in which idx becomes 0 through advancement from W-1; it SHALL be 0 otherwise.
REQ-018 In SCAN with load=1: idx <= A, counter <= 0, S <= one-hot(A), wrap <= 0.
- load takes priority over advancement in the same cycle.
REQ-019 load SHALL be ignored in DIRECT and OFF.
REQ-020 On a DIRECT->SCAN transition, scanning SHALL start from the current idx with the counter at 0; the first advance occurs DWELL cycles after the transition edge.
REQ-021 On an OFF->SCAN transition (E rising), scanning SHALL resume at the held idx and held counter value; S SHALL show one-hot(idx) one cycle after E rises.
REQ-022 With DWELL=1, idx SHALL advance on every SCAN cycle.
REQ-023 Whenever E=1 after the first registered cycle, S SHALL equal one-hot(idx) exactly: never zero and never multi-hot.
REQ-024 The dwell counter width SHALL be clog2(DWELL), with a minimum of 1; arithmetic SHALL NOT overflow for any legal DWELL.

Reset
REQ-025 When rst is asserted: S=0, idx=0, wrap=0, dwell counter=0, state OFF, effective immediately and independent of clk.
REQ-026 Reset asserted mid-scan SHALL abort the scan with no wrap pulse.
REQ-027 After rst deasserts, the first rising edge SHALL evaluate inputs normally.

Verification (N=3, DWELL=4 unless stated)
REQ-028 Direct decode: E=1, mode=0, A=5 -> next cycle S=8'b00100000 and idx=5; then E=0 -> next cycle S=0 and idx=5.
REQ-029 Scan and wrap: reset, then E=1, mode=1 for 40 cycles ->
- idx steps 0,1,...,7,0, each value held 4 cycles.
- wrap high for exactly one cycle, when idx returns to 0 (cycle 32 after start).
REQ-030 Load priority: in SCAN at idx=3 with the counter at 3, assert load=1 with A=6 -> next cycle idx=6, S=8'b01000000; the next advance to 7 occurs 4 cycles later.
REQ-031 Pause and resume: in SCAN at idx=2 with the counter at 1, E=0 for 10 cycles ->
- S=0 while disabled, idx stays 2.
- After E=1, idx advances to 3 three cycles later.
REQ-032 Async reset and DWELL=1: pulse rst between edges while idx=7 -> S=0, idx=0 immediately, no wrap. With DWELL=1 in SCAN, idx increments every cycle and wrap recurs every 8 cycles.

Source files
------------

// File: rtl/decodificador_varredura.sv
// One-hot address decoder with an auto-scan mode: direct decode of A, or a
// stepping scan that dwells DWELL cycles per position and pulses wrap on rollover.
module decodificador_varredura #(
    parameter int unsigned N     = 3,
    parameter int unsigned DWELL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                E,
    input  logic                mode,
    input  logic                load,
    input  logic [N-1:0]        A,
    output logic [(2**N)-1:0]   S,
    output logic [N-1:0]        idx,
    output logic                wrap
);

    localparam int unsigned W        = 2**N;
    localparam int unsigned CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]  IDX_LAST = N'(W - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DIRECT,
        ST_SCAN
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_cur;
    logic [N-1:0]  idx_nxt;
    logic [W-1:0]  s_nxt;
    logic          wrap_nxt;

    // State and all outputs are registered together so every input change lands one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_OFF;
            cnt   <= '0;
            idx   <= '0;
            S     <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            S     <= s_nxt;
            wrap  <= wrap_nxt;
        end
    end

    // Mode is re-decoded every cycle; the action taken on an edge follows the inputs at that edge.
    always_comb begin
        state_nxt = ST_OFF;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        s_nxt     = '0;
        wrap_nxt  = 1'b0;
        cnt_cur   = (state == ST_DIRECT) ? '0 : cnt;

        if (E) begin
            state_nxt = mode ? ST_SCAN : ST_DIRECT;
        end

        unique case (state_nxt)
            ST_DIRECT: begin
                idx_nxt = A;
                cnt_nxt = '0;
                s_nxt   = W'(1) << A;
            end
            ST_SCAN: begin
                // A load wins over a pending advance in the same cycle.
                if (load) begin
                    idx_nxt = A;
                    cnt_nxt = '0;
                end else if (cnt_cur == CNT_LAST) begin
                    cnt_nxt  = '0;
                    idx_nxt  = idx + N'(1);
                    wrap_nxt = (idx == IDX_LAST);
                end else begin
                    cnt_nxt = cnt_cur + CW'(1);
                end
                s_nxt = W'(1) << idx_nxt;
            end
            default: begin
                cnt_nxt = cnt;
            end
        endcase
    end

endmodule

// File: tb/tb_decodificador_varredura.sv
// Scoreboard bench for decodificador_varredura: DWELL=4 and DWELL=1 instances,
// expected {S,idx,wrap} queued per driven edge and compared by a monitor.
module tb_decodificador_varredura;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, E0, mode0, load0;
    logic [2:0] A0;
    logic [7:0] S0;
    logic [2:0] idx0;
    logic       wrap0;

    logic       rst1, E1, mode1, load1;
    logic [2:0] A1;
    logic [7:0] S1;
    logic [2:0] idx1;
    logic       wrap1;

    decodificador_varredura #(.N(3), .DWELL(4)) dut0 (
        .clk(clk), .rst(rst0), .E(E0), .mode(mode0), .load(load0), .A(A0),
        .S(S0), .idx(idx0), .wrap(wrap0)
    );

    decodificador_varredura #(.N(3), .DWELL(1)) dut1 (
        .clk(clk), .rst(rst1), .E(E1), .mode(mode1), .load(load1), .A(A1),
        .S(S1), .idx(idx1), .wrap(wrap1)
    );

    int total = 0;
    int bad   = 0;

    logic [11:0] q0[$];
    logic [11:0] q1[$];
    string       n0[$];
    string       n1[$];

    function automatic logic [11:0] ex(input logic [2:0] i, input logic on, input logic w);
        logic [7:0] s;
        s = on ? (8'd1 << i) : 8'd0;
        return {s, i, w};
    endfunction

    task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got S=%h idx=%0d wrap=%b, want S=%h idx=%0d wrap=%b",
                     nm, $time, act[11:4], act[3:1], act[0], exp[11:4], exp[3:1], exp[0]);
        end
    endtask

    // Monitor: every edge, compare whatever the stimulus queued for that edge.
    always @(posedge clk) begin
        logic [11:0] e;
        string       nm;
        #1;
        if (q0.size() > 0) begin
            e  = q0.pop_front();
            nm = n0.pop_front();
            check(nm, {S0, idx0, wrap0}, e);
        end
        if (q1.size() > 0) begin
            e  = q1.pop_front();
            nm = n1.pop_front();
            check(nm, {S1, idx1, wrap1}, e);
        end
    end

    task automatic step0(input logic e_i, input logic m_i, input logic l_i,
                         input logic [2:0] a_i, input logic [11:0] exp, input string nm);
        E0 = e_i; mode0 = m_i; load0 = l_i; A0 = a_i;
        q0.push_back(exp);
        n0.push_back(nm);
        @(posedge clk);
        #2;
    endtask

    task automatic step1(input logic e_i, input logic m_i, input logic [11:0] exp, input string nm);
        E1 = e_i; mode1 = m_i; load1 = 1'b0; A1 = 3'd0;
        q1.push_back(exp);
        n1.push_back(nm);
        @(posedge clk);
        #2;
    endtask

    // Reset pulse entirely between edges; outputs must clear without a clock.
    task automatic rst_pulse0(input string nm);
        rst0 = 1'b1;
        #1;
        check(nm, {S0, idx0, wrap0}, 12'h000);
        #2;
        rst0 = 1'b0;
    endtask

    initial begin
        rst0 = 1'b1; E0 = 1'b0; mode0 = 1'b0; load0 = 1'b0; A0 = 3'd0;
        rst1 = 1'b1; E1 = 1'b0; mode1 = 1'b0; load1 = 1'b0; A1 = 3'd0;
        #1;
        check("reset_state", {S0, idx0, wrap0}, 12'h000);
        #11;
        rst0 = 1'b0;

        // Direct decode, blanking and ignored load
        step0(1, 0, 0, 3'd5, ex(3'd5, 1, 0), "direct5");
        step0(0, 0, 0, 3'd5, ex(3'd5, 0, 0), "off_hold5");
        step0(1, 0, 0, 3'd0, ex(3'd0, 1, 0), "direct0");
        step0(1, 0, 0, 3'd7, ex(3'd7, 1, 0), "direct7");
        step0(0, 0, 0, 3'd3, ex(3'd7, 0, 0), "off_hold7");
        step0(1, 0, 1, 3'd2, ex(3'd2, 1, 0), "direct_load_ignored");
        step0(0, 1, 1, 3'd6, ex(3'd2, 0, 0), "off_load_ignored");

        rst_pulse0("rst_async");

        // Scan from reset: each position held 4 edges, wrap on edge 32
        for (int k = 1; k <= 47; k++) begin
            step0(1, 1, 0, 3'd0, ex(3'(k / 4), 1, k == 32), "scan");
        end

        // idx=3, cnt=3: load wins over advance
        step0(1, 1, 1, 3'd6, ex(3'd6, 1, 0), "load_prio");
        for (int k = 0; k < 3; k++) step0(1, 1, 0, 3'd0, ex(3'd6, 1, 0), "load_dwell");
        step0(1, 1, 0, 3'd0, ex(3'd7, 1, 0), "load_adv");

        // Pause at idx=2, cnt=1, then resume
        step0(1, 1, 1, 3'd2, ex(3'd2, 1, 0), "load2");
        step0(1, 1, 0, 3'd0, ex(3'd2, 1, 0), "cnt1");
        for (int k = 0; k < 10; k++) step0(0, 1, 0, 3'd0, ex(3'd2, 0, 0), "paused");
        step0(1, 1, 0, 3'd0, ex(3'd2, 1, 0), "resume");
        step0(1, 1, 0, 3'd0, ex(3'd2, 1, 0), "resume");
        step0(1, 1, 0, 3'd0, ex(3'd3, 1, 0), "resume_adv");

        // Direct -> scan from idx=7: counter restarts, wrap on the rollover only
        step0(1, 0, 0, 3'd7, ex(3'd7, 1, 0), "direct7b");
        for (int k = 0; k < 3; k++) step0(1, 1, 0, 3'd0, ex(3'd7, 1, 0), "d2s_dwell");
        step0(1, 1, 0, 3'd0, ex(3'd0, 1, 1), "d2s_wrap");
        step0(1, 1, 0, 3'd0, ex(3'd0, 1, 0), "wrap_once");

        // Reset mid-scan at idx=7 aborts with no wrap
        step0(1, 1, 1, 3'd7, ex(3'd7, 1, 0), "load7");
        step0(1, 1, 0, 3'd0, ex(3'd7, 1, 0), "scan7");
        rst_pulse0("rst_midscan");
        step0(1, 1, 0, 3'd0, ex(3'd0, 1, 0), "post_rst");
        step0(1, 1, 0, 3'd0, ex(3'd0, 1, 0), "post_rst2");
        E0 = 1'b0;

        // DWELL=1: advance every edge, wrap every 8 edges
        rst1 = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            step1(1, 1, ex(3'(k), 1, (k % 8) == 0), "dwell1");
        end

        for (int i = 0; i < 5 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
        #3;
        if (q0.size() > 0 || q1.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", q0.size() + q1.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
